operand_loader: RTL and testbench



---
 rtl/operand_loader_pkg.sv | 15 +
 rtl/operand_loader_btn_debounce.sv | 68 ++++++
 rtl/operand_loader.sv | 116 +++++++++++
 tb/tb_operand_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and widths for the operand loader slice.
// Optional debounce is selected by OPERAND_LOADER_DEBOUNCE_EN.
package operand_loader_pkg;

  localparam int OPERAND_W = 4;
  localparam int DBC_W     = 16;

  // Encoding 2'd3 is unreachable; the FSM maps it back to GET_A.
  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, optional debounce counter, rise pulse.
// The counter exists only when OPERAND_LOADER_DEBOUNCE_EN is defined.
module btn_debounce
  import operand_loader_pkg::*;
#(
  parameter logic [DBC_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic w_level;

  // Two-stage synchronizer for the raw button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  logic             r_level;
  logic [DBC_W-1:0] r_cnt;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= {DBC_W{1'b0}};
    end else if (r_sync2 == r_level) begin
      r_cnt <= {DBC_W{1'b0}};
    end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
      r_level <= r_sync2;
      r_cnt   <= {DBC_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_level = r_level;
`else
  // Without debounce the period setting has no effect.
  logic w_unused_dbc;
  assign w_unused_dbc = ^DEBOUNCE_CYCLES;
  assign w_level      = r_sync2;
`endif

  // Previous accepted level, for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= w_level;
    end
  end

  assign o_pulse = w_level & ~r_level_d;

endmodule

// File: rtl/operand_loader.sv
// Captures two operands from one switch bank on successive load presses.
// Define OPERAND_LOADER_DEBOUNCE_EN to enable button debounce counters.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter logic [DBC_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_load,
  input  logic                 btn_clr,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 valid,
  output logic                 want_b
);

  logic [OPERAND_W-1:0] r_sw_s1;
  logic [OPERAND_W-1:0] r_sw_s2;
  logic [OPERAND_W-1:0] r_a;
  logic [OPERAND_W-1:0] r_b;
  logic                 r_valid;
  logic                 r_want_b;
  state_t               r_state;
  logic                 w_load_pulse;
  logic                 w_clr_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_dbc (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_load),
    .o_pulse (w_load_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_dbc (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_clr),
    .o_pulse (w_clr_pulse)
  );

  // Switch bank synchronizer; operands are captured from the second stage only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= {OPERAND_W{1'b0}};
      r_sw_s2 <= {OPERAND_W{1'b0}};
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Entry FSM; status flags are set alongside the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= GET_A;
      r_a      <= {OPERAND_W{1'b0}};
      r_b      <= {OPERAND_W{1'b0}};
      r_valid  <= 1'b0;
      r_want_b <= 1'b0;
    end else if (w_clr_pulse) begin
      r_state  <= GET_A;
      r_a      <= {OPERAND_W{1'b0}};
      r_b      <= {OPERAND_W{1'b0}};
      r_valid  <= 1'b0;
      r_want_b <= 1'b0;
    end else begin
      case (r_state)
        GET_A: begin
          if (w_load_pulse) begin
            r_a      <= r_sw_s2;
            r_state  <= GET_B;
            r_want_b <= 1'b1;
          end else begin
            r_want_b <= 1'b0;
          end
          r_valid <= 1'b0;
        end
        GET_B: begin
          if (w_load_pulse) begin
            r_b      <= r_sw_s2;
            r_state  <= READY;
            r_valid  <= 1'b1;
            r_want_b <= 1'b0;
          end else begin
            r_valid  <= 1'b0;
            r_want_b <= 1'b1;
          end
        end
        READY: begin
          if (w_load_pulse) begin
            r_a      <= r_sw_s2;
            r_state  <= GET_B;
            r_valid  <= 1'b0;
            r_want_b <= 1'b1;
          end else begin
            r_valid  <= 1'b1;
            r_want_b <= 1'b0;
          end
        end
        default: begin
          r_state  <= GET_A;
          r_valid  <= 1'b0;
          r_want_b <= 1'b0;
        end
      endcase
    end
  end

  assign a      = r_a;
  assign b      = r_b;
  assign valid  = r_valid;
  assign want_b = r_want_b;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a cycle-level reference model.
// Works with OPERAND_LOADER_DEBOUNCE_EN defined (DEBOUNCE_CYCLES=4) or undefined.
module tb_operand_loader;

  localparam int DBC = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = DBC + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       btn_load = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] a;
  logic [3:0] b;
  logic       valid;
  logic       want_b;

  int n_checks = 0;
  int n_fail = 0;

  operand_loader #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clr  (btn_clr),
    .a        (a),
    .b        (b),
    .valid    (valid),
    .want_b   (want_b)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 is the load button, index 1 the clear button.
  bit           m_s1[2];
  bit           m_s2[2];
  bit           m_acc[2];
  bit           m_accp[2];
  logic [DBC-1:0] m_hist[2];
  logic [3:0]   m_sw1 = 4'd0;
  logic [3:0]   m_sw2 = 4'd0;
  logic [3:0]   m_a = 4'd0;
  logic [3:0]   m_b = 4'd0;
  int           m_st = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_acc[i] = 1'b0; m_accp[i] = 1'b0;
      m_hist[i] = '0;
    end
    m_sw1 = 4'd0; m_sw2 = 4'd0; m_a = 4'd0; m_b = 4'd0; m_st = 0;
  endtask

  task automatic model_step();
    bit pl;
    bit pc;
    bit raw[2];
    raw[0] = btn_load;
    raw[1] = btn_clr;
    pl = m_acc[0] & ~m_accp[0];
    pc = m_acc[1] & ~m_accp[1];
    if (pc) begin
      m_a = 4'd0; m_b = 4'd0; m_st = 0;
    end else if (pl) begin
      if (m_st == 0) begin m_a = m_sw2; m_st = 1; end
      else if (m_st == 1) begin m_b = m_sw2; m_st = 2; end
      else begin m_a = m_sw2; m_st = 1; end
    end
    for (int i = 0; i < 2; i++) begin
      m_accp[i] = m_acc[i];
`ifdef OPERAND_LOADER_DEBOUNCE_EN
      // Accept once the last DBC synchronized samples all disagree with the level.
      m_hist[i] = {m_hist[i][DBC-2:0], m_s2[i]};
      if (m_hist[i] == {DBC{~m_acc[i]}}) m_acc[i] = ~m_acc[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
`else
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
      m_acc[i] = m_s2[i];
`endif
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_a", {28'd0, a}, {28'd0, m_a});
    chk("model_b", {28'd0, b}, {28'd0, m_b});
    chk("model_valid", {31'd0, valid}, (m_st == 2) ? 32'd1 : 32'd0);
    chk("model_want_b", {31'd0, want_b}, (m_st == 1) ? 32'd1 : 32'd0);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_a", {28'd0, a}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    repeat (2) @(negedge clk);

    // Basic pair: first operand, with latency edge pinned.
    sw = 4'd9; btn_load = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("a_before_latency", {28'd0, a}, 32'd0);
    @(posedge clk);
    #1 chk("a_first", {28'd0, a}, 32'd9);
    chk("want_b_first", {31'd0, want_b}, 32'd1);
    chk("valid_first", {31'd0, valid}, 32'd0);
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);

    sw = 4'd3; btn_load = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("b_before_latency", {28'd0, b}, 32'd0);
    @(posedge clk);
    #1 chk("b_second", {28'd0, b}, 32'd3);
    chk("valid_second", {31'd0, valid}, 32'd1);
    chk("want_b_second", {31'd0, want_b}, 32'd0);
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);

    // Bounce: 1,0,1,0 one cycle each, then low.
    btn_load = 1'b1; @(negedge clk);
    btn_load = 1'b0; @(negedge clk);
    btn_load = 1'b1; @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    chk("bounce_a", {28'd0, a}, 32'd9);
    chk("bounce_b", {28'd0, b}, 32'd3);
    chk("bounce_valid", {31'd0, valid}, 32'd1);
`endif

    // New pair from READY.
    sw = 4'd12; btn_load = 1'b1;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    chk("newpair_a", {28'd0, a}, 32'd12);
    chk("newpair_b", {28'd0, b}, 32'd3);
    chk("newpair_valid", {31'd0, valid}, 32'd0);
    chk("newpair_want_b", {31'd0, want_b}, 32'd1);

    // Asynchronous reset mid-entry, with the load button still held afterwards.
    sw = 4'd7; btn_load = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_a", {28'd0, a}, 32'd0);
    chk("async_rst_b", {28'd0, b}, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_want_b", {31'd0, want_b}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_after_rst_a", {28'd0, a}, 32'd7);
    chk("held_after_rst_want_b", {31'd0, want_b}, 32'd1);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);

    // Clear and load accepted on the same edge while in GET_B.
    sw = 4'd10; btn_load = 1'b1; btn_clr = 1'b1;
    repeat (10) @(negedge clk);
    btn_load = 1'b0; btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    chk("clr_prio_a", {28'd0, a}, 32'd0);
    chk("clr_prio_b", {28'd0, b}, 32'd0);
    chk("clr_prio_valid", {31'd0, valid}, 32'd0);
    chk("clr_prio_want_b", {31'd0, want_b}, 32'd0);

    // Single-cycle load press from GET_A.
    sw = 4'd5; btn_load = 1'b1;
    @(negedge clk);
    btn_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    repeat (12) @(negedge clk);
    chk("short_press_a", {28'd0, a}, 32'd0);
    chk("short_press_want_b", {31'd0, want_b}, 32'd0);
`else
    chk("short_press_a", {28'd0, a}, 32'd5);
    chk("short_press_want_b", {31'd0, want_b}, 32'd1);
`endif
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
